// File: rtl/down_count_ctrl.sv
// down_count_ctrl: start/stop sequencing controller around a WIDTH-bit down
// counter with a clock prescaler. One-shot or periodic auto-reload.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   start     level-sampled: latch load_val/mode and begin counting
//   stop      level-sampled: abort the countdown (beats start)
//   mode      0 = one-shot, 1 = periodic (latched at start)
//   load_val  preset value (latched at start)
//   count     current counter value (registered)
//   busy      high while running
//   done      one-cycle pulse at terminal count
module down_count_ctrl #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] load_q,  load_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             mode_q,  mode_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             tick_c;

    // Prescaler terminal value marks a decrement tick.
    assign tick_c = (presc_q == PS_LAST);

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load_d  = load_q;
        presc_d = presc_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (stop) begin
            // Abort freezes count; in IDLE it is simply a hold.
            if (state_q == RUN) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                presc_d = '0;
            end
        end else if (start) begin
            presc_d = '0;
            if (load_val != '0) begin
                count_d = load_val;
                load_d  = load_val;
                mode_d  = mode;
                state_d = RUN;
                busy_d  = 1'b1;
            end else begin
                // Zero preset terminates immediately without running.
                count_d = '0;
                done_d  = 1'b1;
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        end else if (state_q == RUN) begin
            presc_d = tick_c ? '0 : presc_q + PW'(1);
            if (tick_c) begin
                if (count_q > WIDTH'(1)) begin
                    count_d = count_q - WIDTH'(1);
                end else begin
                    done_d = 1'b1;
                    if (mode_q) begin
                        count_d = load_q;
                    end else begin
                        count_d = '0;
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            load_q  <= '0;
            presc_q <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            load_q  <= load_d;
            presc_q <= presc_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_down_count_ctrl.sv
// Testbench for down_count_ctrl: a PRESCALE=1 and a PRESCALE=3 instance share
// stimulus; both are checked each cycle against a closed-form timing model,
// the PRESCALE=1 instance also against a vector table.
module tb_down_count_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       mode;
    logic [3:0] load_val;
    logic [3:0] c1, c3;
    logic       b1, b3, d1, d3;

    always #5 clk = ~clk;

    down_count_ctrl #(.WIDTH(4), .PRESCALE(1)) u_p1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
        .load_val(load_val), .count(c1), .busy(b1), .done(d1)
    );

    down_count_ctrl #(.WIDTH(4), .PRESCALE(3)) u_p3 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
        .load_val(load_val), .count(c3), .busy(b3), .done(d3)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int e     = 0;

    // Model: a run is described by its start edge, preset and mode; outputs
    // are computed from elapsed edges rather than tracked step by step.
    int mp[2] = '{1, 3};
    int m_act[2], m_k[2], m_n[2], m_md[2], m_cnt[2], m_dn[2];

    typedef struct {
        logic       st;
        logic       sp;
        logic       md;
        logic [3:0] ld;
        logic [3:0] c;
        logic       b;
        logic       d;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_k[i] = 0; m_n[i] = 0;
            m_md[i] = 0; m_cnt[i] = 0; m_dn[i] = 0;
        end
    endtask

    task automatic model_edge(input int i);
        int d, t, r;
        if (!reset) begin
            m_act[i] = 0; m_cnt[i] = 0; m_dn[i] = 0; m_n[i] = 0; m_md[i] = 0;
        end else if (stop) begin
            m_act[i] = 0;
            m_dn[i]  = 0;
        end else if (start) begin
            if (load_val != 0) begin
                m_act[i] = 1; m_k[i] = e; m_n[i] = int'(load_val);
                m_md[i] = int'(mode); m_cnt[i] = m_n[i]; m_dn[i] = 0;
            end else begin
                m_act[i] = 0; m_cnt[i] = 0; m_dn[i] = 1;
            end
        end else if (m_act[i] != 0) begin
            d = e - m_k[i];
            t = d / mp[i];
            m_dn[i] = 0;
            if (d % mp[i] == 0) begin
                if (m_md[i] == 0) begin
                    m_cnt[i] = m_n[i] - t;
                    if (m_cnt[i] == 0) begin
                        m_dn[i]  = 1;
                        m_act[i] = 0;
                    end
                end else begin
                    r = t % m_n[i];
                    m_cnt[i] = (r == 0) ? m_n[i] : m_n[i] - r;
                    m_dn[i]  = (r == 0) ? 1 : 0;
                end
            end
        end else begin
            m_dn[i] = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_p1_count"}, 32'(c1), 32'(m_cnt[0]));
        chk({tag, "_p1_busy"},  32'(b1), 32'(m_act[0]));
        chk({tag, "_p1_done"},  32'(d1), 32'(m_dn[0]));
        chk({tag, "_p3_count"}, 32'(c3), 32'(m_cnt[1]));
        chk({tag, "_p3_busy"},  32'(b3), 32'(m_act[1]));
        chk({tag, "_p3_done"},  32'(d3), 32'(m_dn[1]));
    endtask

    // Advance one clock edge; inputs are already stable, sample 1ns after.
    task automatic step(input string tag);
        e++;
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_in(input logic st, input logic sp, input logic md, input logic [3:0] ld);
        start = st; stop = sp; mode = md; load_val = ld;
    endtask

    task automatic add(input logic st, input logic sp, input logic md, input logic [3:0] ld,
                       input logic [3:0] c, input logic b, input logic d);
        vec_t v;
        v.st = st; v.sp = sp; v.md = md; v.ld = ld; v.c = c; v.b = b; v.d = d;
        tbl.push_back(v);
    endtask

    // Asynchronous reset mid-cycle: outputs must clear before any edge.
    task automatic async_reset(input string tag);
        reset = 1'b0;
        model_clear();
        #1;
        check_all(tag);
        step({tag, "_hold"});
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_c3[6] = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd1, 4'd0};
        logic       exp_d3[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       exp_b3[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // One-shot load 5.
        add(1,0,0,4'd5, 4'd5,1,0); add(0,0,0,4'd5, 4'd4,1,0);
        add(0,0,0,4'd5, 4'd3,1,0); add(0,0,0,4'd5, 4'd2,1,0);
        add(0,0,0,4'd5, 4'd1,1,0); add(0,0,0,4'd5, 4'd0,0,1);
        add(0,0,0,4'd5, 4'd0,0,0); add(0,0,0,4'd5, 4'd0,0,0);
        // Periodic load 3, then stop.
        add(1,0,1,4'd3, 4'd3,1,0); add(0,0,0,4'd7, 4'd2,1,0);
        add(0,0,0,4'd7, 4'd1,1,0); add(0,0,0,4'd7, 4'd3,1,1);
        add(0,0,0,4'd7, 4'd2,1,0); add(0,0,0,4'd7, 4'd1,1,0);
        add(0,0,0,4'd7, 4'd3,1,1); add(0,1,0,4'd7, 4'd3,0,0);
        add(0,0,0,4'd7, 4'd3,0,0);
        // Stop beats start at count 6, then start load 2.
        add(1,0,0,4'd9, 4'd9,1,0); add(0,0,0,4'd9, 4'd8,1,0);
        add(0,0,0,4'd9, 4'd7,1,0); add(0,0,0,4'd9, 4'd6,1,0);
        add(1,1,0,4'd2, 4'd6,0,0); add(1,0,0,4'd2, 4'd2,1,0);
        add(0,0,0,4'd2, 4'd1,1,0); add(0,0,0,4'd2, 4'd0,0,1);
        add(0,0,0,4'd2, 4'd0,0,0);
        // Zero preset: done only.
        add(1,0,1,4'd0, 4'd0,0,1); add(0,0,0,4'd0, 4'd0,0,0);
        // Restart mid-run at count 4 with load 10.
        add(1,0,0,4'd6, 4'd6,1,0); add(0,0,0,4'd6, 4'd5,1,0);
        add(0,0,0,4'd6, 4'd4,1,0); add(1,0,0,4'd10, 4'd10,1,0);
        add(0,0,0,4'd3, 4'd9,1,0); add(0,1,0,4'd3, 4'd9,0,0);

        // Reset held low with start asserted.
        model_clear();
        reset = 1'b0;
        set_in(1, 0, 0, 4'd5);
        #1;
        check_all("rst_init");
        step("rst_hold");
        reset = 1'b1;
        set_in(0, 0, 0, 4'd5);
        step("post_rst");
        step("post_rst");

        // Vector table.
        foreach (tbl[j]) begin
            set_in(tbl[j].st, tbl[j].sp, tbl[j].md, tbl[j].ld);
            step("tbl");
            chk($sformatf("vec%0d_count", j), 32'(c1), 32'(tbl[j].c));
            chk($sformatf("vec%0d_busy", j),  32'(b1), 32'(tbl[j].b));
            chk($sformatf("vec%0d_done", j),  32'(d1), 32'(tbl[j].d));
        end

        // Prescale 3, one-shot load 2.
        async_reset("arst_a");
        set_in(1, 0, 0, 4'd2);
        step("ps3_start");
        chk("ps3_start_count", 32'(c3), 32'd2);
        set_in(0, 0, 0, 4'd2);
        for (int j = 0; j < 6; j++) begin
            step("ps3_run");
            chk($sformatf("ps3_count%0d", j), 32'(c3), 32'(exp_c3[j]));
            chk($sformatf("ps3_done%0d", j),  32'(d3), 32'(exp_d3[j]));
            chk($sformatf("ps3_busy%0d", j),  32'(b3), 32'(exp_b3[j]));
        end

        // Reset mid-count: immediate clear, no done.
        set_in(1, 0, 1, 4'd5);
        step("ps3_start2");
        set_in(0, 0, 0, 4'd5);
        for (int j = 0; j < 4; j++) step("ps3_run2");
        reset = 1'b0;
        model_clear();
        #1;
        chk("midrst_count", 32'(c3), 32'd0);
        chk("midrst_busy",  32'(b3), 32'd0);
        chk("midrst_done",  32'(d3), 32'd0);
        step("midrst_hold");
        reset = 1'b1;
        step("midrst_rel");

        // Randomised traffic.
        for (int j = 0; j < 3000; j++) begin
            set_in(($urandom % 8) == 0, ($urandom % 25) == 0, 1'($urandom),
                   (($urandom % 6) == 0) ? 4'd0 : 4'($urandom_range(1, 15)));
            if (($urandom % 500) == 0) async_reset("rnd_arst");
            else                       step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
